// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, widths and
// default latencies used by both the decoder and the MDU itself.
package mdu_pkg;

    localparam int OP_W             = 4;
    localparam int DATA_W           = 32;
    localparam int DEF_MULT_CYCLES  = 5;
    localparam int DEF_DIV_CYCLES   = 10;

    typedef enum logic [OP_W-1:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    // Only the four arithmetic ops occupy the unit for multiple cycles.
    function automatic logic isLaunchOp(input logic [OP_W-1:0] code);
        return (code == MDU_MULT) || (code == MDU_MULTU) ||
               (code == MDU_DIV)  || (code == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO. Results are computed
// combinationally from latched operands and committed on the final count.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       A,
    input  logic [31:0]       B,
    input  logic [OP_W-1:0]   op,
    input  logic              start,
    output logic              busy,
    output logic [31:0]       out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] count;
    logic [31:0]      opA;
    logic [31:0]      opB;
    mdu_op_e          pendOp;
    logic [31:0]      hi;
    logic [31:0]      lo;

    logic             launch;
    logic             finalCount;
    logic [63:0]      sProd;
    logic [63:0]      uProd;
    logic [31:0]      sDivisor;
    logic [31:0]      uDivisor;
    logic [31:0]      sQuo;
    logic [31:0]      sRem;
    logic [31:0]      uQuo;
    logic [31:0]      uRem;
    logic             sOverflow;

    assign busy       = (count != '0);
    assign launch     = start && !busy && isLaunchOp(op);
    assign finalCount = (count == CNT_W'(1));

    // INT_MIN / -1 is rerouted to a divide-by-one, which yields exactly the
    // wrapped quotient (INT_MIN) and zero remainder; divide-by-zero is also
    // routed to one so the datapath never sees an undefined division.
    assign sOverflow = (opA == 32'h8000_0000) && (opB == 32'hFFFF_FFFF);
    assign sDivisor  = ((opB == '0) || sOverflow) ? 32'd1 : opB;
    assign uDivisor  = (opB == '0) ? 32'd1 : opB;

    assign sProd = $signed({{32{opA[31]}}, opA}) * $signed({{32{opB[31]}}, opB});
    assign uProd = {32'b0, opA} * {32'b0, opB};
    assign sQuo  = $signed(opA) / $signed(sDivisor);
    assign sRem  = $signed(opA) % $signed(sDivisor);
    assign uQuo  = opA / uDivisor;
    assign uRem  = opA % uDivisor;

    // Counter, operand latches and pending op: load on launch, count down to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            opA    <= '0;
            opB    <= '0;
            pendOp <= MDU_NONE;
        end else if (launch) begin
            count  <= (op == MDU_MULT || op == MDU_MULTU) ? CNT_W'(MULT_CYCLES)
                                                          : CNT_W'(DIV_CYCLES);
            opA    <= A;
            opB    <= B;
            pendOp <= mdu_op_e'(op);
        end else if (busy) begin
            count <= count - CNT_W'(1);
            if (finalCount) pendOp <= MDU_NONE;
        end
    end

    // HI/LO: commit the arithmetic result on the last busy edge; moves-to
    // only land while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (busy) begin
            if (finalCount) begin
                case (pendOp)
                    MDU_MULT:  {hi, lo} <= sProd;
                    MDU_MULTU: {hi, lo} <= uProd;
                    MDU_DIV: begin
                        if (opB != '0) begin
                            lo <= sQuo;
                            hi <= sRem;
                        end
                    end
                    MDU_DIVU: begin
                        if (opB != '0) begin
                            lo <= uQuo;
                            hi <= uRem;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (op == MDU_MTHI) begin
            hi <= A;
        end else if (op == MDU_MTLO) begin
            lo <= A;
        end
    end

    always_comb begin
        out = '0;
        case (op)
            MDU_MFHI: out = hi;
            MDU_MFLO: out = lo;
            default:  out = '0;
        endcase
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed vector table, hand-written busy/reset
// sequences and randomized ops against a plain-arithmetic HI/LO model.
module tb_mdu;
    import mdu_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  op;
    logic        start;
    logic        busy;
    logic [31:0] out;

    int testsRun;
    int testsFailed;

    logic [31:0] modelHi;
    logic [31:0] modelLo;

    typedef struct {
        logic [3:0]  vecOp;
        logic [31:0] vecA;
        logic [31:0] vecB;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          expCycles;
    } vector_t;

    mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .op    (op),
        .start (start),
        .busy  (busy),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive inputs at the next falling edge so they are stable for the rising edge.
    task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic s);
        @(negedge clk);
        op    = o;
        A     = a;
        B     = b;
        start = s;
    endtask

    task automatic readReg(input logic [3:0] which, output logic [31:0] val);
        logic [3:0] saved;
        saved = op;
        op = which;
        #1;
        val = out;
        op = saved;
        #1;
    endtask

    task automatic checkRegs(input string name);
        logic [31:0] v;
        readReg(MDU_MFHI, v);
        checkOutput({name, " HI"}, v, modelHi);
        readReg(MDU_MFLO, v);
        checkOutput({name, " LO"}, v, modelLo);
    endtask

    // Pulse start for one cycle; returns at the first falling edge after launch.
    task automatic launchOp(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        applyStimulus(o, a, b, 1'b1);
        applyStimulus(MDU_NONE, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic countBusy(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic moveTo(input logic [3:0] o, input logic [31:0] v);
        applyStimulus(o, v, 32'h0, 1'b0);
        applyStimulus(MDU_NONE, 32'h0, 32'h0, 1'b0);
        if (o == MDU_MTHI) modelHi = v;
        else               modelLo = v;
    endtask

    // Reference model: HI/LO effect of one arithmetic op, straight from the ISA rules.
    task automatic modelOp(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        logic [63:0] qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            MDU_MULT: begin
                p = 64'(sa * sb);
                modelHi = p[63:32];
                modelLo = p[31:0];
            end
            MDU_MULTU: begin
                p = 64'(a) * 64'(b);
                modelHi = p[63:32];
                modelLo = p[31:0];
            end
            MDU_DIV: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                qv = 64'(q);
                rv = 64'(r);
                modelLo = qv[31:0];
                modelHi = rv[31:0];
            end
            MDU_DIVU: if (b != 0) begin
                modelLo = a / b;
                modelHi = a % b;
            end
            default: ;
        endcase
    endtask

    function automatic int cyclesFor(input logic [3:0] o);
        return (o == MDU_MULT || o == MDU_MULTU) ? MULT_N : DIV_N;
    endfunction

    vector_t vecs[6];

    initial begin
        int          cyc;
        logic [31:0] v;
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        testsRun    = 0;
        testsFailed = 0;
        modelHi     = '0;
        modelLo     = '0;
        op    = MDU_NONE;
        A     = '0;
        B     = '0;
        start = 1'b0;
        reset = 1'b1;

        vecs[0] = '{MDU_MULT,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, MULT_N};
        vecs[1] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, MULT_N};
        vecs[2] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N};
        vecs[3] = '{MDU_DIVU,  32'd7,         32'd2,         32'h0000_0001, 32'h0000_0003, DIV_N};
        vecs[4] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_N};
        vecs[5] = '{MDU_MULT,  32'd3,         32'd4,         32'h0000_0000, 32'h0000_000C, MULT_N};

        repeat (2) @(negedge clk);
        checkOutput("reset busy", {31'b0, busy}, 32'h0);
        reset = 1'b0;
        checkRegs("reset state");
        readReg(MDU_NONE, v);
        checkOutput("op NONE out", v, 32'h0);

        // Directed vector table
        foreach (vecs[i]) begin
            launchOp(vecs[i].vecOp, vecs[i].vecA, vecs[i].vecB);
            countBusy(cyc);
            checkOutput($sformatf("vec%0d cycles", i), cyc, vecs[i].expCycles);
            modelHi = vecs[i].expHi;
            modelLo = vecs[i].expLo;
            checkRegs($sformatf("vec%0d", i));
        end

        // MTHI/MTLO take effect in the very next cycle
        moveTo(MDU_MTHI, 32'h11);
        moveTo(MDU_MTLO, 32'h22);
        checkRegs("mthi/mtlo");

        // Divide by zero: full latency, HI/LO untouched
        launchOp(MDU_DIV, 32'd5, 32'd0);
        countBusy(cyc);
        checkOutput("div0 cycles", cyc, DIV_N);
        checkRegs("div0");
        launchOp(MDU_DIVU, 32'd9, 32'd0);
        countBusy(cyc);
        checkRegs("divu0");

        // MTLO while busy is dropped
        launchOp(MDU_MULT, 32'd3, 32'd4);
        applyStimulus(MDU_MTLO, 32'h55, 32'h0, 1'b0);
        applyStimulus(MDU_NONE, 32'h0, 32'h0, 1'b0);
        countBusy(cyc);
        modelOp(MDU_MULT, 32'd3, 32'd4);
        checkRegs("mtlo busy");

        // Second start during busy is ignored
        launchOp(MDU_MULT, 32'd6, 32'd7);
        applyStimulus(MDU_DIVU, 32'd100, 32'd7, 1'b1);
        applyStimulus(MDU_NONE, 32'h0, 32'h0, 1'b0);
        countBusy(cyc);
        checkOutput("restart cycles", cyc, MULT_N - 2);
        modelOp(MDU_MULT, 32'd6, 32'd7);
        checkRegs("restart ignored");

        // Start sampled on the falling-busy edge is rejected, accepted next cycle
        launchOp(MDU_MULTU, 32'd2, 32'd3);
        repeat (MULT_N - 1) @(negedge clk);
        op = MDU_DIVU; A = 32'd9; B = 32'd2; start = 1'b1;
        @(negedge clk);
        checkOutput("edge start rejected", {31'b0, busy}, 32'h0);
        modelOp(MDU_MULTU, 32'd2, 32'd3);
        checkRegs("edge result");
        @(negedge clk);
        start = 1'b0; op = MDU_NONE;
        countBusy(cyc);
        checkOutput("edge retry cycles", cyc, DIV_N);
        modelOp(MDU_DIVU, 32'd9, 32'd2);
        checkRegs("edge retry");

        // Reset mid-operation clears everything at once
        moveTo(MDU_MTHI, 32'h11);
        moveTo(MDU_MTLO, 32'h22);
        launchOp(MDU_MULT, 32'd3, 32'd4);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midreset busy", {31'b0, busy}, 32'h0);
        modelHi = '0;
        modelLo = '0;
        checkRegs("midreset");
        @(negedge clk);
        reset = 1'b0;
        repeat (MULT_N + 1) @(negedge clk);
        checkOutput("postreset busy", {31'b0, busy}, 32'h0);
        checkRegs("postreset");

        // Randomized ops against the model
        for (int n = 0; n < 40; n++) begin
            rop = 4'(MDU_MULT + $urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: begin ra = $urandom_range(0, 200); rb = $urandom_range(1, 20); end
                2: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            launchOp(rop, ra, rb);
            countBusy(cyc);
            checkOutput($sformatf("rand%0d cycles", n), cyc, cyclesFor(rop));
            modelOp(rop, ra, rb);
            checkRegs($sformatf("rand%0d op%0d %h %h", n, rop, ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. It sits beside the ALU and feeds `ex_mem`. It owns the architectural HI/LO registers. It executes mult/multu/div/divu over a fixed number of cycles and raises `busy` so the hazard unit can stall MDU-dependent instructions in ID. mfhi/mflo results leave through `out` and travel down the pipeline like ALU results.

## Interface
Parameters:
- MULT_CYCLES, 5: cycles `busy` stays high for mult/multu.
- DIV_CYCLES, 10: cycles `busy` stays high for div/divu.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- A  in  32  rs operand (forwarded value).
- B  in  32  rt operand (forwarded value).
- op  in  4  operation code; encodings are defined in `mdu_pkg`.
- start  in  1  one-cycle pulse; launches the mult/multu/div/divu given on `op`.
- busy  out  1  high while an operation is in flight.
- out  out  32  HI when `op` is MFHI, LO when `op` is MFLO, else 0; combinational.

## Operation
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8. Codes 9-15 behave as NONE.
- Launch: `start`=1 with `!busy` and op in MULT..DIVU.
  - Latches A and B.
  - Loads the cycle counter with MULT_CYCLES or DIV_CYCLES.
  - Records the pending op.
- Accepted `start` when `busy`=1: ignored. The hazard unit never issues this case. The in-flight operation continues unchanged.
- `start` with any other op: ignored.
- MULT: {HI,LO} = signed 64-bit product. MULTU: unsigned product.
- DIV: LO = signed quotient, truncated toward zero; HI = remainder, same sign as dividend.
- DIVU: unsigned quotient/remainder.
- Divisor 0 (DIV/DIVU): HI/LO stay unchanged. `busy` still runs the full DIV_CYCLES.
- DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0 (two's-complement wrap).
- MTHI/MTLO: when `busy`=0, HI (resp. LO) <= A on the next edge. When `busy`=1 the write is dropped.
- MFHI/MFLO: `out` reads the current HI/LO register. It does not forward an in-flight result.
- Result registers: compute the result combinationally from the latched operands. Commit it only on the final count. Intermediate HI/LO values are never visible.
- Reset: asynchronous, mid-operation included.
  - busy=0, counter=0, HI=0, LO=0, latched operands=0, pending op=NONE.
  - The in-flight result is discarded.

## Timing
- Edge E0 samples `start`. `busy` is 1 from just after E0 through E0+N.
- `busy` deasserts just after edge E0+N, where N = MULT_CYCLES or DIV_CYCLES. HI/LO update at that same edge.
- An mfhi in ID during the cycle after `busy` falls reads the new value.
- The hazard unit stalls on (`busy` | `start`). This module does not combine them.
- Back-to-back: `start` sampled at edge E0+N (the same edge `busy` falls) is rejected. It is accepted from edge E0+N+1 onward.
- MTHI/MTLO latency: one edge. `out` reflects the new value in the following cycle.
- `out` has zero latency from `op`/HI/LO. There is no register on the output.
- Counter width: $clog2(max(MULT_CYCLES,DIV_CYCLES)+1) bits. It counts down to 0 and never wraps.

## Structure
- `mdu_pkg`: op encodings (MDU_NONE..MDU_MTLO), the op width constant, and default cycle counts.
- The decoder in `ctrl` imports `mdu_pkg` to drive `op`/`start`. `ex_mem` is unaffected except for carrying `out` on its AO path.
- Single module, no sub-modules. Arithmetic uses the `*`, `/`, `%` operators on 64-/32-bit signed and unsigned casts.

## Test plan
- Reset mid-operation: start MULT 3*4, assert reset at cycle 2. Expect busy=0, HI=LO=0 immediately; after release, MFLO gives out=0.
- MULT vs MULTU: A=0xFFFFFFFF, B=2. MULT: busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU: HI=1, LO=0xFFFFFFFE.
- DIV signed: A=-7, B=2. busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 gives LO=3, HI=1.
- Divide by zero: preload HI=0x11, LO=0x22 via MTHI/MTLO, then DIV by 0. busy runs 10 cycles; HI/LO remain 0x11/0x22.
- Busy interactions:
  - MTLO A=0x55 while busy is dropped.
  - A second `start` during busy is ignored; the original result commits.
  - `start` on the falling-busy edge is rejected; it is accepted one cycle later.
- MFHI/MFLO: out tracks HI/LO combinationally. op=NONE gives out=0.
